// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: per-channel synchroniser, stability counter and rise/fall pulses.
// Optional long-press pulse per channel is compiled in with DEBOUNCE_LONG_PRESS_EN.
module debounce_bank #(
    parameter int unsigned          CHANNELS       = 4,
    parameter int unsigned          DEBOUNCE_LIMIT = 250000,
    parameter int unsigned          SYNC_STAGES    = 2,
    parameter logic [CHANNELS-1:0]  INIT_STATE     = '0,
    parameter int unsigned          LONG_LIMIT     = 25000000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [CHANNELS-1:0] SW,
    output logic [CHANNELS-1:0] SW_debounced,
    output logic [CHANNELS-1:0] SW_rise,
    output logic [CHANNELS-1:0] SW_fall,
    output logic [CHANNELS-1:0] SW_long
);

    localparam int unsigned   CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    if (CHANNELS < 1 || DEBOUNCE_LIMIT < 2 || SYNC_STAGES < 2 || LONG_LIMIT < 2) begin : g_bad_param
        $error("debounce_bank: illegal parameter value");
    end

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;

    // Metastability synchroniser on the raw pins
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= INIT_STATE;
        end else begin
            sync_q[0] <= SW;
            for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             state_q, state_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;

        // Any cycle of agreement discards the accumulated mismatch count
        always_comb begin
            cnt_d   = '0;
            state_d = state_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (s[i] != state_q) begin
                if (cnt_q == CNT_MAX) begin
                    state_d = s[i];
                    rise_d  = s[i];
                    fall_d  = ~s[i];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                cnt_q   <= '0;
                state_q <= INIT_STATE[i];
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                state_q <= state_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign SW_debounced[i] = state_q;
        assign SW_rise[i]      = rise_q;
        assign SW_fall[i]      = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
        localparam int unsigned      LONG_W    = $clog2(LONG_LIMIT);
        localparam logic [LONG_W-1:0] LONG_TERM = LONG_W'(LONG_LIMIT - 1);

        logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
        logic              long_q, long_d;

        // Hold counter is 0 in the rise cycle and saturates at terminal count
        always_comb begin
            long_cnt_d = long_cnt_q;
            long_d     = 1'b0;
            if (!state_d) begin
                long_cnt_d = '0;
            end else if (state_q && long_cnt_q != LONG_TERM) begin
                long_cnt_d = long_cnt_q + LONG_W'(1);
                long_d     = (long_cnt_d == LONG_TERM);
            end
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                long_cnt_q <= '0;
                long_q     <= 1'b0;
            end else begin
                long_cnt_q <= long_cnt_d;
                long_q     <= long_d;
            end
        end

        assign SW_long[i] = long_q;
`endif
    end

`ifndef DEBOUNCE_LONG_PRESS_EN
    assign SW_long = '0;
`endif

endmodule
